// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte master and the HT16K33 command sequencer.
// State encoding, quarter-phase names and display command bytes live here.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      ADDR  = 3'd2,
      ACK1  = 3'd3,
      DATA  = 3'd4,
      ACK2  = 3'd5,
      STOP  = 3'd6
   } state_t;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam logic [7:0] HT_OSC_ON    = 8'h21;
   localparam logic [7:0] HT_DISP_ON   = 8'h81;
   localparam logic [6:0] HT_BASE_ADDR = 7'h70;

endpackage

// File: rtl/i2c_byte_master_if.sv
// Request/response handshake between a command source and the I2C byte master.
// The requester uses the master modport; the byte master uses the slave modport.
interface i2c_byte_master_if;

   logic       start;
   logic [6:0] address;
   logic       rw;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       busy;
   logic       ack;

   modport master (
      output start, address, rw, data_in,
      input  data_out, busy, ack
   );

   modport slave (
      input  start, address, rw, data_in,
      output data_out, busy, ack
   );

endinterface

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator; held cleared while the bus is idle so every
// transaction starts from the same phase.
module i2c_clk_div #(
   parameter int CLK_DIV = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   logic [9:0] cnt_reg;
   logic       tick_reg;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_reg  <= '0;
         tick_reg <= 1'b0;
      end else if (cnt_reg == 10'(CLK_DIV - 1)) begin
         cnt_reg  <= '0;
         tick_reg <= 1'b1;
      end else begin
         cnt_reg  <= cnt_reg + 10'd1;
         tick_reg <= 1'b0;
      end
   end

   assign tick = tick_reg;

endmodule

// File: rtl/i2c_byte_master.sv
// Single-transaction I2C master: START, address+R/W, one data byte, STOP.
// All bus changes happen on quarter ticks; scl is push-pull, sda open-drain.
module i2c_byte_master
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 30
) (
   input  logic             clk,
   input  logic             rst,
   i2c_byte_master_if.slave req,
   output logic             scl,
   inout  wire              sda
);

   state_t     state_reg, state_next;
   logic [1:0] q_reg, q_next;
   logic [2:0] bit_reg, bit_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] wdata_reg, wdata_next;
   logic       rw_reg, rw_next;
   logic       scl_reg, scl_next;
   logic       sda_low_reg, sda_low_next;
   logic       busy_reg, busy_next;
   logic       ack_reg, ack_next;
   logic       ack_acc_reg, ack_acc_next;
   logic [7:0] data_out_reg, data_out_next;
   logic       start_q_reg;
   logic       tick;
   logic       sda_level;

   i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk  (clk),
      .rst  (rst),
      .en   (busy_reg),
      .tick (tick)
   );

   assign sda_level    = sda;
   assign sda          = sda_low_reg ? 1'b0 : 1'bz;
   assign scl          = scl_reg;
   assign req.busy     = busy_reg;
   assign req.ack      = ack_reg;
   assign req.data_out = data_out_reg;

   always_comb begin
      state_next    = state_reg;
      q_next        = q_reg;
      bit_next      = bit_reg;
      shift_next    = shift_reg;
      wdata_next    = wdata_reg;
      rw_next       = rw_reg;
      scl_next      = scl_reg;
      sda_low_next  = sda_low_reg;
      busy_next     = busy_reg;
      ack_next      = ack_reg;
      ack_acc_next  = ack_acc_reg;
      data_out_next = data_out_reg;

      if (state_reg == IDLE) begin
         if (req.start && !start_q_reg) begin
            shift_next   = {req.address, req.rw};
            rw_next      = req.rw;
            wdata_next   = req.data_in;
            busy_next    = 1'b1;
            ack_acc_next = 1'b1;
            q_next       = Q0;
            bit_next     = '0;
            state_next   = START;
         end
      end else if (tick) begin
         q_next = q_reg + 2'd1;
         unique case (state_reg)
            START: begin
               if (q_reg == Q1) sda_low_next = 1'b1;
               if (q_reg == Q3) state_next = ADDR;
            end
            ADDR, DATA: begin
               unique case (q_reg)
                  Q0: begin
                     scl_next     = 1'b0;
                     // A read releases sda for the slave to drive the data bits.
                     sda_low_next = (state_reg == DATA && rw_reg) ? 1'b0 : ~shift_reg[7];
                  end
                  Q1: scl_next = 1'b1;
                  Q2: shift_next = {shift_reg[6:0], sda_level};
                  Q3: begin
                     bit_next = bit_reg + 3'd1;
                     if (bit_reg == 3'd7) state_next = (state_reg == ADDR) ? ACK1 : ACK2;
                  end
               endcase
            end
            ACK1, ACK2: begin
               unique case (q_reg)
                  Q0: begin
                     scl_next     = 1'b0;
                     sda_low_next = 1'b0;
                  end
                  Q1: scl_next = 1'b1;
                  Q2: if (state_reg == ACK1 || !rw_reg) ack_acc_next = ack_acc_reg & ~sda_level;
                  Q3: begin
                     if (state_reg == ACK1 && ack_acc_reg) begin
                        shift_next = wdata_reg;
                        state_next = DATA;
                     end else begin
                        state_next = STOP;
                     end
                  end
               endcase
            end
            STOP: begin
               unique case (q_reg)
                  Q0: begin
                     scl_next     = 1'b0;
                     sda_low_next = 1'b1;
                  end
                  Q1: scl_next = 1'b1;
                  Q2: sda_low_next = 1'b0;
                  Q3: begin
                     busy_next  = 1'b0;
                     ack_next   = ack_acc_reg;
                     if (rw_reg && ack_acc_reg) data_out_next = shift_reg;
                     state_next = IDLE;
                  end
               endcase
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // Tracks start even in reset so a level held across reset cannot retrigger.
      start_q_reg <= req.start;
      if (rst) begin
         state_reg    <= IDLE;
         q_reg        <= Q0;
         bit_reg      <= '0;
         shift_reg    <= '0;
         wdata_reg    <= '0;
         rw_reg       <= 1'b0;
         scl_reg      <= 1'b1;
         sda_low_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         ack_reg      <= 1'b0;
         ack_acc_reg  <= 1'b0;
         data_out_reg <= '0;
      end else begin
         state_reg    <= state_next;
         q_reg        <= q_next;
         bit_reg      <= bit_next;
         shift_reg    <= shift_next;
         wdata_reg    <= wdata_next;
         rw_reg       <= rw_next;
         scl_reg      <= scl_next;
         sda_low_reg  <= sda_low_next;
         busy_reg     <= busy_next;
         ack_reg      <= ack_next;
         ack_acc_reg  <= ack_acc_next;
         data_out_reg <= data_out_next;
      end
   end

endmodule
